cr_su_arb: RTL and testbench

CR_SU_ARB -- requirements
Module: cr_su_arb

---
 rtl/cr_su_arb.sv | 161 ++++++++++++++++
 tb/tb_cr_su_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_su_arb.sv
// cr_su_arb: round-robin arbiter merging N_REQ engine scheduler-update
// requests into one registered output stream, with a forced idle gap.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid      per-requester update pending
//   req_data       per-requester payload, flattened N_REQ x PAYLOAD_W
//   req_ack        one-cycle grant pulse (combinational)
//   su_ready       downstream FIFO has space
//   arb_enable     permits new grants
//   su_out_valid   registered one-cycle valid toward the scheduler
//   su_out_data    registered granted payload (held when not valid)
//   last_grant_id  index of the most recent grant
//   cnt_clr        clears all grant counters
//   grant_cnt      per-requester saturating grant count, N_REQ x 16

module cr_su_arb #(
    parameter int N_REQ     = 4,
    parameter int PAYLOAD_W = 96,
    parameter int MIN_GAP   = 2,
    localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*PAYLOAD_W-1:0] req_data,
    output logic [N_REQ-1:0]           req_ack,
    input  logic                       su_ready,
    input  logic                       arb_enable,
    output logic                       su_out_valid,
    output logic [PAYLOAD_W-1:0]       su_out_data,
    output logic [IDW-1:0]             last_grant_id,
    input  logic                       cnt_clr,
    output logic [N_REQ*16-1:0]        grant_cnt
);

    localparam logic [3:0] GAP_LOAD =
        (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

    typedef enum logic [0:0] {
        S_IDLE,
        S_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           gap_q, gap_d;
    logic [IDW-1:0]       last_q;
    logic                 sov_q;
    logic [PAYLOAD_W-1:0] sod_q;
    logic [15:0]          cnt_q [N_REQ];

    logic                 found;
    logic [IDW-1:0]       gid;
    logic                 grant;

    // Round-robin search starting just past the previous winner.
    // last_q <= N_REQ-1 and i <= N_REQ-1, so one subtraction wraps.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        gid   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(last_q) + 1 + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req_valid[j]) begin
                found = 1'b1;
                gid   = IDW'(j);
            end
        end
    end

    // found already implies req_valid != 0; rst masks any ack.
    assign grant = (state_q == S_IDLE) && arb_enable && su_ready
                   && found && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic; GAP ignores every input and always completes.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant && (MIN_GAP > 0)) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gap_d   = 4'd0;
            end
        endcase
    end

    // Output logic: ack pulses only in the grant cycle.
    always_comb begin
        req_ack = '0;
        if (grant) begin
            req_ack[gid] = 1'b1;
        end
    end

    // Registered output stage and ordering pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sov_q  <= 1'b0;
            sod_q  <= '0;
            last_q <= IDW'(N_REQ - 1);
        end else begin
            sov_q <= grant;
            if (grant) begin
                sod_q  <= req_data[int'(gid)*PAYLOAD_W +: PAYLOAD_W];
                last_q <= gid;
            end
        end
    end

    // Saturating grant counters; a clear drops a coincident grant.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst || cnt_clr) begin
                cnt_q[i] <= 16'd0;
            end else if (grant && (int'(gid) == i)
                         && (cnt_q[i] != 16'hFFFF)) begin
                cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end

    assign su_out_valid  = sov_q;
    assign su_out_data   = sod_q;
    assign last_grant_id = last_q;

endmodule

// File: tb/tb_cr_su_arb.sv
// tb_cr_su_arb: directed bench for cr_su_arb with a per-instance
// scoreboard of expected output beats (cycle, id, payload).

module tb_cr_su_arb;

    localparam int NR = 4;
    localparam int PW = 96;

    typedef struct {
        int          cyc;
        logic [1:0]  id;
        logic [95:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int fails  = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // Instance a: MIN_GAP=2, b: MIN_GAP=0, c: MIN_GAP=3
    logic           rst_a, rst_b, rst_c;
    logic [NR-1:0]  rv_a, rv_b, rv_c;
    logic [NR*PW-1:0] rd_a, rd_b, rd_c;
    logic [NR-1:0]  ack_a, ack_b, ack_c;
    logic           rdy_a, rdy_b, rdy_c;
    logic           en_a, en_b, en_c;
    logic           ov_a, ov_b, ov_c;
    logic [PW-1:0]  od_a, od_b, od_c;
    logic [1:0]     lg_a, lg_b, lg_c;
    logic           clr_a, clr_b, clr_c;
    logic [NR*16-1:0] gc_a, gc_b, gc_c;

    cr_su_arb #(.N_REQ(NR), .PAYLOAD_W(PW), .MIN_GAP(2)) u_a (
        .clk(clk), .rst(rst_a), .req_valid(rv_a), .req_data(rd_a),
        .req_ack(ack_a), .su_ready(rdy_a), .arb_enable(en_a),
        .su_out_valid(ov_a), .su_out_data(od_a),
        .last_grant_id(lg_a), .cnt_clr(clr_a), .grant_cnt(gc_a)
    );

    cr_su_arb #(.N_REQ(NR), .PAYLOAD_W(PW), .MIN_GAP(0)) u_b (
        .clk(clk), .rst(rst_b), .req_valid(rv_b), .req_data(rd_b),
        .req_ack(ack_b), .su_ready(rdy_b), .arb_enable(en_b),
        .su_out_valid(ov_b), .su_out_data(od_b),
        .last_grant_id(lg_b), .cnt_clr(clr_b), .grant_cnt(gc_b)
    );

    cr_su_arb #(.N_REQ(NR), .PAYLOAD_W(PW), .MIN_GAP(3)) u_c (
        .clk(clk), .rst(rst_c), .req_valid(rv_c), .req_data(rd_c),
        .req_ack(ack_c), .su_ready(rdy_c), .arb_enable(en_c),
        .su_out_valid(ov_c), .su_out_data(od_c),
        .last_grant_id(lg_c), .cnt_clr(clr_c), .grant_cnt(gc_c)
    );

    function automatic logic [95:0] pay(input int inst, input int i);
        logic [95:0] p;
        p = {32'hC0DE_0000 + 32'(inst * 16 + i),
             32'h1234_5678 ^ 32'(i * 3 + 1),
             32'hFEED_0000 | 32'(i + inst * 4)};
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int c, input int id,
                                input logic [95:0] d);
        exp_t e;
        e.cyc  = c;
        e.id   = 2'(id);
        e.data = d;
        return e;
    endfunction

    // Monitors: pop and compare whenever a DUT presents an output.
    always @(negedge clk) begin
        if (ov_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_out_cycle", 128'(cyc), 128'(e.cyc));
                chk("a_out_id", 128'(lg_a), 128'(e.id));
                chk("a_out_data", 128'(od_a), 128'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (ov_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_out_cycle", 128'(cyc), 128'(e.cyc));
                chk("b_out_id", 128'(lg_b), 128'(e.id));
                chk("b_out_data", 128'(od_b), 128'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (ov_c) begin
            if (q_c.size() == 0) begin
                chk("c_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_c.pop_front();
                chk("c_out_cycle", 128'(cyc), 128'(e.cyc));
                chk("c_out_id", 128'(lg_c), 128'(e.id));
                chk("c_out_data", 128'(od_c), 128'(e.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            rd_a[i*PW +: PW] = pay(1, i);
            rd_b[i*PW +: PW] = pay(2, i);
            rd_c[i*PW +: PW] = pay(3, i);
        end
        rst_a = 1; rst_b = 1; rst_c = 1;
        clr_a = 0; clr_b = 0; clr_c = 0;
        rdy_a = 1; rdy_b = 1; rdy_c = 1;
        en_a  = 1; en_b  = 1; en_c  = 1;
        // requests present during reset must not be acked
        rv_a = 4'b1111; rv_b = 4'b0000; rv_c = 4'b0000;
        nxt;
        @(negedge clk);
        chk("ack_during_reset", 128'(ack_a), 0);
        nxt;
        nxt;
        rst_a = 0; rst_b = 0; rst_c = 0;

        // Reset values
        @(negedge clk);
        chk("a_rst_valid", 128'(ov_a), 0);
        chk("a_rst_data", 128'(od_a), 0);
        chk("a_rst_last", 128'(lg_a), 3);
        chk("a_rst_cnt", 128'(gc_a), 0);
        chk("b_rst_last", 128'(lg_b), 3);

        // Round robin, MIN_GAP=2: acks 0,1,2,3 on cycles 0,3,6,9
        for (int c = 0; c < 12; c++) begin
            logic [3:0] ea;
            if (c != 0) @(negedge clk);
            ea = (c % 3 == 0) ? 4'(1 << (c / 3)) : 4'b0000;
            chk($sformatf("a_rr_ack_c%0d", c), 128'(ack_a), 128'(ea));
            if (c % 3 == 0) q_a.push_back(mk(cyc + 1, c / 3, pay(1, c / 3)));
            nxt;
        end

        // su_ready low holds off a pending request
        rv_a  = 4'b0100;
        rdy_a = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("a_notready_ack", 128'(ack_a), 0);
            nxt;
        end
        rdy_a = 1;
        @(negedge clk);
        chk("a_ready_ack", 128'(ack_a), 128'(4'b0100));
        q_a.push_back(mk(cyc + 1, 2, pay(1, 2)));
        nxt;
        rv_a = 0;
        @(negedge clk);
        chk("a_last_grant", 128'(lg_a), 2);
        nxt;
        @(negedge clk);
        chk("a_hold_valid", 128'(ov_a), 0);
        chk("a_hold_data", 128'(od_a), 128'(pay(1, 2)));
        chk("a_counts", 128'(gc_a), 128'({16'd1, 16'd2, 16'd1, 16'd1}));

        // MIN_GAP=0: back-to-back alternation 0,1,0,1
        nxt;
        rv_b = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("b_alt_ack_c%0d", c), 128'(ack_b),
                128'((c % 2 == 1) ? 4'b0010 : 4'b0001));
            if (c > 0) chk("b_alt_valid", 128'(ov_b), 1);
            q_b.push_back(mk(cyc + 1, c % 2, pay(2, c % 2)));
            nxt;
        end
        rv_b = 0;
        @(negedge clk);
        chk("b_counts", 128'(gc_b), 128'({16'd0, 16'd0, 16'd4, 16'd4}));
        nxt;
        clr_b = 1;
        nxt;
        clr_b = 0;
        @(negedge clk);
        chk("b_clr", 128'(gc_b), 0);

        // Drive counter 0 up to 16'hFFFE, then into saturation
        nxt;
        rv_b = 4'b0001;
        for (int k = 0; k < 65534; k++) begin
            @(negedge clk);
            q_b.push_back(mk(cyc + 1, 0, pay(2, 0)));
            nxt;
        end
        rv_b = 0;
        @(negedge clk);
        chk("b_cnt_fffe", 128'(gc_b[15:0]), 128'(16'hFFFE));
        nxt;
        rv_b = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            q_b.push_back(mk(cyc + 1, 0, pay(2, 0)));
            nxt;
        end
        rv_b = 0;
        @(negedge clk);
        chk("b_cnt_sat", 128'(gc_b[15:0]), 128'(16'hFFFF));
        nxt;
        // clear coincident with a grant: grant not counted
        rv_b  = 4'b0001;
        clr_b = 1;
        @(negedge clk);
        chk("b_clr_grant_ack", 128'(ack_b), 128'(4'b0001));
        q_b.push_back(mk(cyc + 1, 0, pay(2, 0)));
        nxt;
        rv_b  = 0;
        clr_b = 0;
        @(negedge clk);
        chk("b_clr_wins", 128'(gc_b), 0);

        // MIN_GAP=3: enable dropped after the grant cycle
        nxt;
        rv_c = 4'b0011;
        @(negedge clk);
        chk("c_first_ack", 128'(ack_c), 128'(4'b0001));
        q_c.push_back(mk(cyc + 1, 0, pay(3, 0)));
        nxt;
        en_c = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("c_gap_noack_k%0d", k), 128'(ack_c), 0);
            nxt;
        end
        en_c = 1;
        @(negedge clk);
        chk("c_reenable_ack", 128'(ack_c), 128'(4'b0010));
        q_c.push_back(mk(cyc + 1, 1, pay(3, 1)));
        nxt;
        rv_c = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("c_gap2_noack", 128'(ack_c), 0);
            nxt;
        end

        // Reset in the middle of GAP aborts it
        rv_c = 4'b0100;
        @(negedge clk);
        chk("c_pre_rst_ack", 128'(ack_c), 128'(4'b0100));
        q_c.push_back(mk(cyc + 1, 2, pay(3, 2)));
        nxt;
        nxt;
        rst_c = 1;
        rv_c  = 4'b0101;
        @(negedge clk);
        chk("c_rst_ack", 128'(ack_c), 0);
        nxt;
        rst_c = 0;
        @(negedge clk);
        chk("c_rst_valid", 128'(ov_c), 0);
        chk("c_rst_data", 128'(od_c), 0);
        chk("c_rst_last", 128'(lg_c), 3);
        chk("c_rst_cnt", 128'(gc_c), 0);
        chk("c_post_rst_ack", 128'(ack_c), 128'(4'b0001));
        q_c.push_back(mk(cyc + 1, 0, pay(3, 0)));
        nxt;
        rv_c = 0;
        nxt;
        nxt;
        @(negedge clk);
        #1;
        chk("a_queue_drained", 128'(q_a.size()), 0);
        chk("b_queue_drained", 128'(q_b.size()), 0);
        chk("c_queue_drained", 128'(q_c.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
